// File: rtl/ntt_perm_pkg.sv
// Shared types and helpers for the stage permutation stream.
// Latency: n/a (types, constant functions only).
// Backpressure: n/a.
package ntt_perm_pkg;

    // Spatial: the permutation stays inside one beat. Buffered: it crosses beats.
    typedef enum logic {
        SPATIAL,
        BUFFERED
    } perm_mode_t;

    typedef enum logic {
        WR_IDLE,
        WR_FILL
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DRAIN
    } rd_state_t;

    // Return i with bit positions a and b exchanged.
    function automatic int unsigned swap_idx(input int unsigned i,
                                             input int unsigned a,
                                             input int unsigned b);
        int unsigned ba;
        int unsigned bb;
        int unsigned r;
        ba = (i >> a) & 32'd1;
        bb = (i >> b) & 32'd1;
        r  = i & ~((32'd1 << a) | (32'd1 << b));
        r  = r | (ba << b) | (bb << a);
        return r;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/perm_frame_bank.sv
// One frame of beats; write a whole beat per cycle, read back a permuted beat.
// Latency: write takes effect at the next edge; read port is combinational.
// Backpressure: none; the owner guarantees read and write never overlap.
module perm_frame_bank
    import ntt_perm_pkg::*;
#(
    parameter int DW     = 28,
    parameter int IPC    = 64,
    parameter int F      = 32,
    parameter int SWAP_A = 0,
    parameter int SWAP_B = 6,
    localparam int LW    = $clog2(IPC),
    localparam int CW    = $clog2(F)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [CW-1:0]           wr_addr,
    input  logic [IPC-1:0][DW-1:0]  wr_dat,
    input  logic [CW-1:0]           rd_addr,
    output logic [IPC-1:0][DW-1:0]  rd_dat
);

    logic [IPC-1:0][DW-1:0] mem [F];

    // Store the incoming beat at its frame position; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Each output lane fetches the element whose global index is swap(own index).
    for (genvar l = 0; l < IPC; l++) begin : g_rd
        int unsigned src;
        assign src       = swap_idx((32'(rd_addr) << LW) | 32'(l), SWAP_A, SWAP_B);
        assign rd_dat[l] = mem[CW'(src >> LW)][LW'(src)];
    end

endmodule

// File: rtl/stage_permutation_stream.sv
// Streams frames and exchanges two global-index bits (in-beat or via ping-pong banks).
// Latency: 1 cycle in spatial mode; 2 edges after the last beat of a frame in buffered mode.
// Backpressure: none; banks alternate so a full-rate stream never stalls.
module stage_permutation_stream
    import ntt_perm_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = 28,
    parameter int INPUT_PER_CYCLE      = 64,
    parameter int N_POINTS             = 2048,
    parameter int SWAP_BIT_A           = 0,
    parameter int SWAP_BIT_B           = 2
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_start,
    input  logic                                                  in_valid,
    input  logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]  inData,
    output logic                                                  out_start,
    output logic                                                  out_valid,
    output logic [INPUT_PER_CYCLE-1:0][DATA_WIDTH_PER_INPUT-1:0]  outData,
    output logic                                                  frame_err
);

    localparam int DW   = DATA_WIDTH_PER_INPUT;
    localparam int IPC  = INPUT_PER_CYCLE;
    localparam int LW   = $clog2(IPC);
    localparam int LOGN = $clog2(N_POINTS);
    localparam perm_mode_t MODE =
        ((SWAP_BIT_A == SWAP_BIT_B) || (SWAP_BIT_A < LW && SWAP_BIT_B < LW)) ? SPATIAL : BUFFERED;

    if (!is_pow2(IPC) || IPC < 2) begin : g_bad_ipc
        $error("INPUT_PER_CYCLE must be a power of two, at least 2");
    end
    if (!is_pow2(N_POINTS) || N_POINTS < IPC) begin : g_bad_n
        $error("N_POINTS must be a power of two and a multiple of INPUT_PER_CYCLE");
    end
    if (SWAP_BIT_A < 0 || SWAP_BIT_A >= LOGN || SWAP_BIT_B < 0 || SWAP_BIT_B >= LOGN) begin : g_bad_swap
        $error("swap bits must lie below log2(N_POINTS)");
    end

    logic [IPC-1:0][DW-1:0] outData_q, outData_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_start_q, out_start_d;
    logic                   frame_err_q, frame_err_d;

    // Output registers, cleared asynchronously so reset silences the port at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outData_q   <= '0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            outData_q   <= outData_d;
            out_valid_q <= out_valid_d;
            out_start_q <= out_start_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign outData   = outData_q;
    assign out_valid = out_valid_q;
    assign out_start = out_start_q;
    assign frame_err = frame_err_q;

    if (MODE == SPATIAL) begin : g_spatial
        logic [IPC-1:0][DW-1:0] spat_perm;

        for (genvar l = 0; l < IPC; l++) begin : g_lane
            assign spat_perm[l] = inData[LW'(swap_idx(l, SWAP_BIT_A, SWAP_BIT_B))];
        end

        // Lane-permute each valid beat; hold the last beat when idle.
        always_comb begin
            outData_d   = outData_q;
            if (in_valid) begin
                outData_d = spat_perm;
            end
            out_valid_d = in_valid;
            out_start_d = in_start;
            frame_err_d = 1'b0;
        end
    end else begin : g_buffered
        localparam int F  = N_POINTS / IPC;
        localparam int CW = $clog2(F);

        wr_state_t              wr_state_q, wr_state_d;
        logic [CW-1:0]          wr_cnt_q, wr_cnt_d;
        logic                   wr_bank_q, wr_bank_d;
        logic [1:0]             full_q, full_d;
        rd_state_t              rd_state_q, rd_state_d;
        logic [CW-1:0]          rd_cnt_q, rd_cnt_d;
        logic                   rd_bank_q, rd_bank_d;
        logic                   wr_en;
        logic [CW-1:0]          wr_addr;
        logic [IPC-1:0][DW-1:0] rd_dat [2];

        for (genvar b = 0; b < 2; b++) begin : g_bank
            perm_frame_bank #(
                .DW     (DW),
                .IPC    (IPC),
                .F      (F),
                .SWAP_A (SWAP_BIT_A),
                .SWAP_B (SWAP_BIT_B)
            ) u_bank (
                .clk     (clk),
                .wr_en   (wr_en && (wr_bank_q == 1'(b))),
                .wr_addr (wr_addr),
                .wr_dat  (inData),
                .rd_addr (rd_cnt_q),
                .rd_dat  (rd_dat[b])
            );
        end

        // Write side fills a bank frame by frame; read side drains full banks back to back.
        always_comb begin
            wr_state_d  = wr_state_q;
            wr_cnt_d    = wr_cnt_q;
            wr_bank_d   = wr_bank_q;
            rd_state_d  = rd_state_q;
            rd_cnt_d    = rd_cnt_q;
            rd_bank_d   = rd_bank_q;
            full_d      = full_q;
            wr_en       = 1'b0;
            wr_addr     = wr_cnt_q;
            frame_err_d = 1'b0;
            out_valid_d = 1'b0;
            out_start_d = 1'b0;
            outData_d   = outData_q;

            case (wr_state_q)
                WR_IDLE: begin
                    // Beats before a frame start are dropped.
                    if (in_valid && in_start) begin
                        wr_en      = 1'b1;
                        wr_addr    = '0;
                        wr_cnt_d   = CW'(1);
                        wr_state_d = WR_FILL;
                    end
                end
                WR_FILL: begin
                    if (in_valid) begin
                        wr_en = 1'b1;
                        if (in_start) begin
                            // A new start abandons the partial frame and refills the same bank.
                            frame_err_d = 1'b1;
                            wr_addr     = '0;
                            wr_cnt_d    = CW'(1);
                        end else if (wr_cnt_q == CW'(F - 1)) begin
                            full_d[wr_bank_q] = 1'b1;
                            wr_bank_d         = ~wr_bank_q;
                            wr_cnt_d          = '0;
                            wr_state_d        = WR_IDLE;
                        end else begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end
                end
                default: wr_state_d = WR_IDLE;
            endcase

            case (rd_state_q)
                RD_IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        rd_state_d = RD_DRAIN;
                        rd_cnt_d   = '0;
                    end
                end
                RD_DRAIN: begin
                    out_valid_d = 1'b1;
                    out_start_d = (rd_cnt_q == '0);
                    outData_d   = rd_dat[rd_bank_q];
                    if (rd_cnt_q == CW'(F - 1)) begin
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        rd_cnt_d          = '0;
                        // Continue straight into the other bank if it is already full.
                        if (!full_q[~rd_bank_q]) begin
                            rd_state_d = RD_IDLE;
                        end
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
                default: rd_state_d = RD_IDLE;
            endcase
        end

        // Bank control state; reset empties both banks and discards any frame in flight.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                wr_state_q <= WR_IDLE;
                wr_cnt_q   <= '0;
                wr_bank_q  <= 1'b0;
                full_q     <= '0;
                rd_state_q <= RD_IDLE;
                rd_cnt_q   <= '0;
                rd_bank_q  <= 1'b0;
            end else begin
                wr_state_q <= wr_state_d;
                wr_cnt_q   <= wr_cnt_d;
                wr_bank_q  <= wr_bank_d;
                full_q     <= full_d;
                rd_state_q <= rd_state_d;
                rd_cnt_q   <= rd_cnt_d;
                rd_bank_q  <= rd_bank_d;
            end
        end
    end

endmodule

// File: tb/tb_stage_permutation_stream.sv
// Directed bench: spatial instance (bits 0,2) and buffered instance (bits 0,6).
// Latency: checks 1-cycle spatial and 2-edge buffered first-beat latency.
// Backpressure: none exercised; the design has none.
module tb_stage_permutation_stream;

    localparam int DW   = 28;
    localparam int IPC  = 64;
    localparam int NB   = 32;
    localparam int CAPN = 512;

    typedef logic [IPC-1:0][DW-1:0] beat_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    logic  sp_st = 1'b0, sp_vl = 1'b0;
    beat_t sp_dat = '0;
    logic  sp_ost, sp_ov, sp_fe;
    beat_t sp_out;
    logic  in_st = 1'b0, in_vl = 1'b0;
    beat_t in_dat = '0;
    logic  bf_st, bf_ov, bf_fe;
    beat_t bf_dat;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stage_permutation_stream u_sp (
        .clk       (clk),
        .rst       (rst),
        .in_start  (sp_st),
        .in_valid  (sp_vl),
        .inData    (sp_dat),
        .out_start (sp_ost),
        .out_valid (sp_ov),
        .outData   (sp_out),
        .frame_err (sp_fe)
    );

    stage_permutation_stream #(
        .SWAP_BIT_A (0),
        .SWAP_BIT_B (6)
    ) u_bf (
        .clk       (clk),
        .rst       (rst),
        .in_start  (in_st),
        .in_valid  (in_vl),
        .inData    (in_dat),
        .out_start (bf_st),
        .out_valid (bf_ov),
        .outData   (bf_dat),
        .frame_err (bf_fe)
    );

    // Capture every buffered output beat with its cycle stamp.
    int    cyc     = 0;
    int    cap_n   = 0;
    int    err_cnt = 0;
    beat_t cap_dat [CAPN];
    logic  cap_st  [CAPN];
    int    cap_cyc [CAPN];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bf_ov === 1'b1 && cap_n < CAPN) begin
            cap_dat[cap_n] <= bf_dat;
            cap_st[cap_n]  <= bf_st;
            cap_cyc[cap_n] <= cyc;
            cap_n          <= cap_n + 1;
        end
        if (bf_fe === 1'b1) err_cnt <= err_cnt + 1;
    end

    function automatic int swp(input int i);
        return (i & ~65) | ((i & 1) << 6) | ((i >> 6) & 1);
    endfunction

    function automatic beat_t mk_in(input int tagv, input int b);
        beat_t r;
        for (int l = 0; l < IPC; l++) r[l] = DW'(tagv + b * IPC + l);
        return r;
    endfunction

    function automatic beat_t mk_exp(input int tagv, input int k);
        beat_t r;
        for (int l = 0; l < IPC; l++) r[l] = DW'(tagv + swp(k * IPC + l));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int k, input beat_t obs, input beat_t exp);
        int bad;
        bad = 0;
        checks++;
        assert (obs === exp) else begin
            failures++;
            for (int l = IPC - 1; l >= 0; l--) if (obs[l] !== exp[l]) bad = l;
            $error("FAIL %s beat=%0d lane=%0d observed=%0d expected=%0d", tag, k, bad, obs[bad], exp[bad]);
        end
    endtask

    task automatic chk_frame(input string tag, input int base, input int tagv);
        chk($sformatf("%s_start0", tag), cap_st[base], 1);
        chk_beat(tag, 0, cap_dat[base], mk_exp(tagv, 0));
        for (int k = 1; k < NB; k++) begin
            chk($sformatf("%s_start%0d", tag, k), cap_st[base + k], 0);
            chk($sformatf("%s_contig%0d", tag, k), cap_cyc[base + k], cap_cyc[base] + k);
            chk_beat(tag, k, cap_dat[base + k], mk_exp(tagv, k));
        end
    endtask

    task automatic drive_beat(input logic st, input int tagv, input int b);
        in_st  = st;
        in_vl  = 1'b1;
        in_dat = mk_in(tagv, b);
        tick();
        in_st  = 1'b0;
        in_vl  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_st = 1'b0;
        in_vl = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int base;
        int e0;
        int e_before;
        int n_rst;

        // Reset state
        repeat (3) tick();
        chk("rst_sp_ov", sp_ov, 0);
        chk("rst_sp_st", sp_ost, 0);
        chk("rst_sp_fe", sp_fe, 0);
        chk("rst_sp_dat0", sp_out[0], 0);
        chk("rst_bf_ov", bf_ov, 0);
        chk("rst_bf_st", bf_st, 0);
        chk("rst_bf_fe", bf_fe, 0);
        chk("rst_bf_dat5", bf_dat[5], 0);
        rst = 1'b1;
        tick();

        // Spatial: lane l = l+100 with start
        sp_st = 1'b1;
        sp_vl = 1'b1;
        for (int l = 0; l < IPC; l++) sp_dat[l] = DW'(l + 100);
        tick();
        chk("sp_start", sp_ost, 1);
        chk("sp_valid", sp_ov, 1);
        chk("sp_lane1", sp_out[1], 104);
        chk("sp_lane4", sp_out[4], 101);
        chk("sp_lane6", sp_out[6], 103);
        // Spatial: lane l = 3*l, no start
        sp_st = 1'b0;
        for (int l = 0; l < IPC; l++) sp_dat[l] = DW'(l * 3);
        tick();
        chk("sp2_start", sp_ost, 0);
        chk("sp2_valid", sp_ov, 1);
        chk("sp2_lane1", sp_out[1], 12);
        chk("sp2_lane5", sp_out[5], 15);
        chk("sp2_fe", sp_fe, 0);
        // Spatial idle: hold data
        sp_vl = 1'b0;
        sp_dat = '1;
        tick();
        chk("sp_idle_valid", sp_ov, 0);
        chk("sp_idle_start", sp_ost, 0);
        chk("sp_idle_hold", sp_out[1], 12);

        // Buffered: one frame, data = global index
        base = cap_n;
        for (int b = 0; b < NB; b++) drive_beat(b == 0, 0, b);
        e0 = cyc;
        idle(40);
        chk("f0_count", cap_n - base, NB);
        chk("f0_latency", cap_cyc[base], e0 + 2);
        chk("f0_b0l1", cap_dat[base][1], 64);
        chk("f0_b1l0", cap_dat[base + 1][0], 1);
        chk("f0_b1l1", cap_dat[base + 1][1], 65);
        chk_frame("f0", base, 0);
        chk("f0_idle_valid", bf_ov, 0);
        chk("f0_idle_start", bf_st, 0);
        chk("f0_idle_hold", bf_dat[0], 1921);
        chk("f0_no_err", err_cnt, 0);

        // Buffered: three back-to-back frames
        base = cap_n;
        for (int f = 1; f <= 3; f++)
            for (int b = 0; b < NB; b++) drive_beat(b == 0, f * 4096, b);
        idle(40);
        chk("bb_count", cap_n - base, 3 * NB);
        chk("bb_contig_all", cap_cyc[base + 3 * NB - 1], cap_cyc[base] + 3 * NB - 1);
        chk_frame("bb1", base, 1 * 4096);
        chk_frame("bb2", base + NB, 2 * 4096);
        chk_frame("bb3", base + 2 * NB, 3 * 4096);

        // Buffered: restart at beat 10
        base = cap_n;
        e_before = err_cnt;
        for (int b = 0; b < 10; b++) drive_beat(b == 0, 5 * 4096, b);
        drive_beat(1'b1, 6 * 4096, 0);
        chk("ab_fe_pulse", bf_fe, 1);
        drive_beat(1'b0, 6 * 4096, 1);
        chk("ab_fe_clear", bf_fe, 0);
        for (int b = 2; b < NB; b++) drive_beat(1'b0, 6 * 4096, b);
        idle(40);
        chk("ab_err_once", err_cnt - e_before, 1);
        chk("ab_count", cap_n - base, NB);
        chk_frame("ab", base, 6 * 4096);

        // Buffered: reset during drain beat 5
        base = cap_n;
        for (int b = 0; b < NB; b++) drive_beat(b == 0, 7 * 4096, b);
        idle(7);
        chk("rd_b5_valid", bf_ov, 1);
        chk("rd_b5_dat", bf_dat[0], 7 * 4096 + 257);
        rst = 1'b0;
        #1;
        chk("rd_rst_valid", bf_ov, 0);
        chk("rd_rst_start", bf_st, 0);
        chk("rd_rst_fe", bf_fe, 0);
        chk("rd_rst_dat", bf_dat[0], 0);
        n_rst = cap_n;
        chk("rd_pre_count", n_rst - base, 5);
        tick();
        tick();
        rst = 1'b1;
        idle(40);
        chk("rd_quiet", cap_n, n_rst);
        for (int b = 0; b < 3; b++) drive_beat(1'b0, 8 * 4096, b + 5);
        idle(5);
        chk("rd_drop_nostart", cap_n, n_rst);
        base = cap_n;
        for (int b = 0; b < NB; b++) drive_beat(b == 0, 8 * 4096, b);
        idle(40);
        chk("rd_new_count", cap_n - base, NB);
        chk_frame("rd_new", base, 8 * 4096);

        // Buffered: two frames with ~50% input gaps
        base = cap_n;
        e0 = 0;
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 1) == 0) idle(1);
                drive_beat(b == 0, (9 + f) * 4096, b);
            end
            if (f == 0) e0 = cyc;
        end
        idle(40);
        chk("gap_count", cap_n - base, 2 * NB);
        chk("gap_latency", cap_cyc[base], e0 + 2);
        chk_frame("gap0", base, 9 * 4096);
        chk_frame("gap1", base + NB, 10 * 4096);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
